pipe_skid_reg: RTL and testbench

Generic, parametrised pipeline stage register that replaces the fixed per-stage latch registers (global load, no backpressure) with a valid/ready elastic stage. It has a 2-entry skid buffer, so upstream can stall from a registered ready with no combinational ready path between stages. It also supports synchronous flush for branch mispredict squash. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying the packed stage payload: control word, dest, operands, predictor state.

---
 rtl/pipe_skid_reg.sv | 111 +++++++++++
 tb/tb_pipe_skid_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Elastic valid/ready pipeline stage register with a 2-entry
//               skid buffer and synchronous flush. All outputs come straight
//               from flops, so there is no combinational path through the
//               stage in either direction.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int              WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Occupancy state; the encoding doubles as the count output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             pop;

    // Handshakes use only the registered ready/valid, never a live input path.
    assign accept = in_valid & in_ready_q & ~flush;
    assign pop    = out_valid_q & out_ready;

    // Next occupancy, data moves and registered handshake flags.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            // Squash drops every entry; data registers keep stale contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move data.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, data and handshake flops; reset clears without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Scoreboard bench for pipe_skid_reg. The driver pushes every
//               payload it expects the stage to take; the monitor pops and
//               compares on each downstream transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int              W     = 16;
    localparam logic [W-1:0]    RDATA = 16'h5A5A;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           delivered = 0;

    pipe_skid_reg #(.WIDTH(W), .RESET_DATA(RDATA)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the expected payload is queued when it will be taken.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (v && in_ready && !f) exp_q.push_back(d);
    endtask

    // Monitor: compare each downstream transfer, then apply any flush.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ovalid_vs_count", {31'd0, out_valid}, {31'd0, (count != 2'd0)});
            chk("iready_vs_count", {31'd0, in_ready},  {31'd0, (count != 2'd2)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
                    delivered++;
                end
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dlv0;
        logic [W-1:0] cnt_data;
        // Reset state, checked while reset is still held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",  {30'd0, count},     32'd0);
        chk("rst_iready", {31'd0, in_ready},  32'd1);
        chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("rst_odata",  {16'd0, out_data},  {16'd0, RDATA});
        @(negedge clk);
        reset = 1'b0;

        // Streaming: one payload per cycle, count pinned at 1.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            if (i > 1) begin
                chk("stream_count",  {30'd0, count},    32'd1);
                chk("stream_iready", {31'd0, in_ready}, 32'd1);
                chk("stream_odata",  {16'd0, out_data}, i - 1);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("stream_last", {16'd0, out_data}, 32'd8);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("stream_empty", {30'd0, count}, 32'd0);

        // Skid: stall downstream as A2 arrives; A3 must wait for in_ready.
        drive(1'b1, 16'h00A1, 1'b1, 1'b0);
        drive(1'b1, 16'h00A2, 1'b0, 1'b0);
        chk("skid_c1", {30'd0, count}, 32'd1);
        drive(1'b1, 16'h00A3, 1'b0, 1'b0);
        chk("skid_full",   {30'd0, count},    32'd2);
        chk("skid_iready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 16'h00A3, 1'b0, 1'b0);
        chk("skid_hold", {30'd0, count}, 32'd2);
        chk("skid_main", {16'd0, out_data}, 32'h00A1);
        drive(1'b1, 16'h00A3, 1'b1, 1'b0);
        drive(1'b1, 16'h00A3, 1'b1, 1'b0);
        chk("skid_shift", {16'd0, out_data}, 32'h00A2);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("skid_a3", {16'd0, out_data}, 32'h00A3);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("skid_drained", {30'd0, count}, 32'd0);

        // Flush with both entries held; B3 offered in the flush cycle.
        drive(1'b1, 16'h00B1, 1'b0, 1'b0);
        drive(1'b1, 16'h00B2, 1'b0, 1'b0);
        drive(1'b1, 16'h00B3, 1'b0, 1'b1);
        chk("fl_pre_count", {30'd0, count}, 32'd2);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("fl_count",  {30'd0, count},     32'd0);
        chk("fl_ovalid", {31'd0, out_valid}, 32'd0);
        chk("fl_iready", {31'd0, in_ready},  32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with a pop: C1 delivered, C2 never taken.
        drive(1'b1, 16'h00C1, 1'b1, 1'b0);
        dlv0 = delivered;
        drive(1'b1, 16'h00C2, 1'b1, 1'b1);
        chk("flpop_count", {30'd0, count}, 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("flpop_deliv", delivered - dlv0, 32'd1);
        chk("flpop_empty", {30'd0, count},     32'd0);
        chk("flpop_ovalid", {31'd0, out_valid}, 32'd0);

        // Async reset mid-transfer, with upstream still offering data.
        drive(1'b1, 16'h00D1, 1'b0, 1'b0);
        drive(1'b1, 16'h00D2, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count",  {30'd0, count},     32'd0);
        chk("arst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("arst_iready", {31'd0, in_ready},  32'd1);
        chk("arst_odata",  {16'd0, out_data},  {16'd0, RDATA});
        exp_q.delete();
        in_data = 16'h00D3;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("arst_noacc", {30'd0, count}, 32'd0);

        // Mixed valid/ready traffic against the scoreboard.
        cnt_data = 16'h1000;
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), cnt_data, 1'($urandom_range(0, 1)), 1'b0);
            if (in_valid && in_ready) cnt_data = cnt_data + 1'b1;
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("final_drain", exp_q.size(), 32'd0);
        chk("final_count", {30'd0, count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
